axis_fifo_sf: RTL
=================

AXIS_FIFO_SF -- requirements
Module: axis_fifo_sf

Interface
REQ-001 SHALL have parameter WIDTH, default 32, tdata width in bits (1..512).
REQ-002 SHALL have parameter SIZE, default 5, log2 of depth; depth = 2**SIZE entries exactly (1..12).
REQ-003 SHALL have parameter AFULL_THRESH, default 2**SIZE-2, occupied level at or above which almost_full asserts.
REQ-004 SHALL have ports: clk  in  1  clock; reset  in  1  asynchronous, active-low reset.
REQ-005 SHALL have port clear  in  1  synchronous flush.
REQ-006 SHALL have ports i_tdata in WIDTH, i_tlast in 1, i_tvalid in 1, i_tready out 1: AXI-stream slave.
REQ-007 SHALL have ports o_tdata out WIDTH, o_tlast out 1, o_tvalid out 1, o_tready in 1: AXI-stream master.
REQ-008 SHALL have ports occupied out SIZE+1 (stored entries), space out SIZE+1 (free entries), almost_full out 1, pkt_count out SIZE+1 (complete packets stored), forced_release out 1 (sticky).

Function
REQ-009 SHALL store {tlast, tdata} per entry; width WIDTH+1.
REQ-010 SHALL accept a write on a rising clk edge when i_tvalid & i_tready; SHALL transfer a read when o_tvalid & o_tready.
REQ-011 SHALL drive i_tready = (occupied != 2**SIZE); no write bypass when full, even with a simultaneous read.
REQ-012 SHALL be first-word-fall-through: o_tdata/o_tlast reflect the head entry combinationally; a word written at edge N is presentable from the cycle after edge N.
REQ-013 SHALL NOT bypass input to output: a write into an empty FIFO is never read in the same cycle.
REQ-014 SHALL sustain one write and one read per cycle when 0 < occupied < 2**SIZE; no bubbles.
REQ-015 SHALL keep occupied + space = 2**SIZE at all times; simultaneous read and write leave occupied unchanged.
REQ-016 SHALL wrap read/write pointers modulo 2**SIZE; SIZE+1-bit pointers distinguish full from empty.
REQ-017 SHALL register almost_full = (occupied >= AFULL_THRESH), updated same edge as occupied.
REQ-018 SHALL hold o_tdata/o_tlast stable while o_tvalid & ~o_tready.
REQ-019 SHALL, on clear, empty the FIFO next edge: occupied=0, space=2**SIZE, pkt_count=0, forced_release=0; clear overrides any simultaneous write/read, and the write is discarded.

Reset
REQ-020 SHALL, while reset=0, asynchronously force pointers to 0, occupied=0, space=2**SIZE, pkt_count=0, almost_full=0, forced_release=0, o_tvalid=0, i_tready=0.
REQ-021 SHALL drive i_tready=1 from the first edge after reset deasserts; reset mid-packet discards all stored data.

Configuration
REQ-022 SHALL support macro AXIS_FIFO_SF_PKT_MODE_EN (store-and-forward).
REQ-023 With AXIS_FIFO_SF_PKT_MODE_EN defined: pkt_count +1 on write with i_tlast, -1 on read with o_tlast, unchanged when both; o_tvalid = (occupied!=0) & ((pkt_count!=0) | release).
REQ-024 With macro defined: release sets when FIFO full and pkt_count==0 (oversize packet), sets forced_release, clears on read of a word with o_tlast; prevents deadlock.
REQ-025 Without macro: o_tvalid = (occupied!=0); pkt_count still counts; forced_release tied 0.

Structure
REQ-026 SHALL place entry struct type (tlast, tdata) and helper function depth(SIZE) in package axis_fifo_sf_pkg.
REQ-027 SHALL instantiate sub-module axis_fifo_sf_ram: 2**SIZE x (WIDTH+1) flop array, synchronous write, asynchronous read.

Verification
REQ-028 SIZE=2, write 4 words 1..4 with o_tready=0 -> i_tready=0 after 4th, occupied=4, space=0; 5th write held off.
REQ-029 SIZE=2, read 4 with i_tvalid=0 -> outputs 1,2,3,4 in order; o_tvalid=0 afterwards; occupied=0.
REQ-030 SIZE=5, continuous write+read for 100 cycles after 1-word prefill -> i_tready and o_tvalid high every cycle, data is an incrementing count.
REQ-031 PKT_MODE_EN, SIZE=3: write 3-word packet, tlast on 3rd -> o_tvalid=0 until edge after 3rd write, then pkt_count=1; read 3 -> pkt_count=0.
REQ-032 PKT_MODE_EN, SIZE=2: 6-word packet -> full with pkt_count=0, forced_release=1, all 6 words delivered in order.
REQ-033 Assert clear with 3 words stored and simultaneous i_tvalid -> next cycle occupied=0, o_tvalid=0, next accepted word appears first at output.

Source files
------------

// File: rtl/axis_fifo_sf_pkg.sv
// Shared types and helpers for the store-and-forward AXI-stream FIFO.
// Entry layout is {tlast, tdata}; the release FSM state lives here too.
package axis_fifo_sf_pkg;

  localparam int MAX_WIDTH = 512;

  // Canonical entry layout; the FIFO stores the low WIDTH bits of tdata.
  typedef struct packed {
    logic                 tlast;
    logic [MAX_WIDTH-1:0] tdata;
  } entry_t;

  typedef enum logic {
    REL_IDLE   = 1'b0,
    REL_FORCED = 1'b1
  } rel_state_t;

  function automatic int depth(input int size);
    return 1 << size;
  endfunction

endpackage

// File: rtl/axis_fifo_sf_ram.sv
// Flop-array storage for axis_fifo_sf: synchronous write, asynchronous read.
module axis_fifo_sf_ram
  import axis_fifo_sf_pkg::*;
#(
  parameter int EW = 33,
  parameter int AW = 5
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [EW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [EW-1:0] rdata
);

  localparam int DEPTH = depth(AW);

  logic [EW-1:0] mem [0:DEPTH-1];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/axis_fifo_sf.sv
// First-word-fall-through AXI-stream FIFO with optional store-and-forward.
// Define AXIS_FIFO_SF_PKT_MODE_EN to hold output until a full packet is stored.
module axis_fifo_sf
  import axis_fifo_sf_pkg::*;
#(
  parameter int WIDTH        = 32,
  parameter int SIZE         = 5,
  parameter int AFULL_THRESH = 2**SIZE - 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic [WIDTH-1:0] i_tdata,
  input  logic             i_tlast,
  input  logic             i_tvalid,
  output logic             i_tready,
  output logic [WIDTH-1:0] o_tdata,
  output logic             o_tlast,
  output logic             o_tvalid,
  input  logic             o_tready,
  output logic [SIZE:0]    occupied,
  output logic [SIZE:0]    space,
  output logic             almost_full,
  output logic [SIZE:0]    pkt_count,
  output logic             forced_release
);

  localparam int            DEPTH   = depth(SIZE);
  localparam logic [SIZE:0] DEPTH_V = (SIZE+1)'(DEPTH);
  localparam logic [SIZE:0] AFULL_V = (SIZE+1)'(AFULL_THRESH);
  localparam logic [SIZE:0] ONE     = (SIZE+1)'(1);

  logic [SIZE:0]  wr_ptr, rd_ptr;
  logic [SIZE:0]  occ_q, space_q, pkt_q;
  logic [SIZE:0]  occ_next, pkt_next;
  logic           ready_q, afull_q;
  logic           full, empty, wr_en, rd_en;
  logic [WIDTH:0] rd_entry;

  // Extra pointer MSB separates a wrapped (full) FIFO from an empty one.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr == {~rd_ptr[SIZE], rd_ptr[SIZE-1:0]});

  assign i_tready = ready_q & ~full;
  assign wr_en    = i_tvalid & i_tready & ~clear;
  assign rd_en    = o_tvalid & o_tready & ~clear;

  assign {o_tlast, o_tdata} = rd_entry;

  assign occupied    = occ_q;
  assign space       = space_q;
  assign almost_full = afull_q;
  assign pkt_count   = pkt_q;

  always_comb begin
    occ_next = occ_q;
    pkt_next = pkt_q;
    if (clear) begin
      occ_next = '0;
      pkt_next = '0;
    end else begin
      case ({wr_en, rd_en})
        2'b10:   occ_next = occ_q + ONE;
        2'b01:   occ_next = occ_q - ONE;
        default: occ_next = occ_q;
      endcase
      case ({wr_en & i_tlast, rd_en & o_tlast})
        2'b10:   pkt_next = pkt_q + ONE;
        2'b01:   pkt_next = pkt_q - ONE;
        default: pkt_next = pkt_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      occ_q   <= '0;
      space_q <= DEPTH_V;
      pkt_q   <= '0;
      afull_q <= 1'b0;
      ready_q <= 1'b0;
    end else begin
      ready_q <= 1'b1;
      occ_q   <= occ_next;
      space_q <= DEPTH_V - occ_next;
      pkt_q   <= pkt_next;
      afull_q <= (occ_next >= AFULL_V);
      if (clear) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (wr_en) wr_ptr <= wr_ptr + ONE;
        if (rd_en) rd_ptr <= rd_ptr + ONE;
      end
    end
  end

  axis_fifo_sf_ram #(
    .EW (WIDTH + 1),
    .AW (SIZE)
  ) u_ram (
    .clk   (clk),
    .we    (wr_en),
    .waddr (wr_ptr[SIZE-1:0]),
    .wdata ({i_tlast, i_tdata}),
    .raddr (rd_ptr[SIZE-1:0]),
    .rdata (rd_entry)
  );

`ifdef AXIS_FIFO_SF_PKT_MODE_EN
  rel_state_t rel_q, rel_next;
  logic       forced_q;

  // A full FIFO with no complete packet can never finish one: release it.
  always_comb begin
    rel_next = rel_q;
    if (clear) begin
      rel_next = REL_IDLE;
    end else begin
      case (rel_q)
        REL_IDLE:   if (full && (pkt_q == '0)) rel_next = REL_FORCED;
        REL_FORCED: if (rd_en && o_tlast)      rel_next = REL_IDLE;
        default:    rel_next = REL_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rel_q    <= REL_IDLE;
      forced_q <= 1'b0;
    end else begin
      rel_q <= rel_next;
      if (clear)
        forced_q <= 1'b0;
      else if ((rel_q == REL_IDLE) && (rel_next == REL_FORCED))
        forced_q <= 1'b1;
    end
  end

  assign o_tvalid       = ~empty & ((pkt_q != '0) | (rel_q == REL_FORCED));
  assign forced_release = forced_q;
`else
  assign o_tvalid       = ~empty;
  assign forced_release = 1'b0;
`endif

endmodule
